// File: rtl/uart_phy_rxd_ex_if.sv
// Received-frame stream between the UART receiver (master) and its sink (slave).
interface uart_phy_rxd_ex_if;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic [3:0] out_error;

    modport master (
        output out_valid,
        output out_data,
        output out_error,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_error,
        output out_ready
    );
endinterface

// File: rtl/uart_phy_rxd_ex.sv
// UART receiver PHY: majority-voted sampling, parity/stop/break checks and a
// valid/ready output stage that accepts a new frame in the same cycle as a handoff.
module uart_phy_rxd_ex #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUDRATE   = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int UART_STOPBIT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_ena,
    input  logic              rxd,
    output logic              rts,
    uart_phy_rxd_ex_if.master stream
);

    localparam int          DIVNUM_I = ((CLOCK_FREQUENCY + UART_BAUDRATE / 2 - 1) / UART_BAUDRATE) - 1;
    localparam logic [15:0] DIVNUM   = 16'(DIVNUM_I);
    localparam logic [15:0] HALF     = 16'(DIVNUM_I / 2);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      state_reg;
    logic [1:0]  sync_reg;
    logic [2:0]  hist_reg;
    logic [1:0]  prime_reg;
    logic        armed_reg;
    logic [15:0] divcount_reg;
    logic [3:0]  bitcnt_reg;
    logic        stopcnt_reg;
    logic [8:0]  data_reg;
    logic        par_bit_reg;
    logic        par_err_reg;
    logic        ferr_reg;
    logic        out_valid_reg;
    logic [8:0]  out_data_reg;
    logic [3:0]  out_error_reg;
    logic        rts_reg;

    logic rxd_s;
    logic sample;
    logic capture;
    logic accept;
    logic stop_ferr;
    logic last_stop;
    logic brk_now;
    logic complete;

    always_comb begin
        rxd_s     = sync_reg[1];
        sample    = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) | (hist_reg[1] & hist_reg[2]);
        capture   = (divcount_reg == 16'd0);
        accept    = out_valid_reg && stream.out_ready;
        stop_ferr = ferr_reg | ~sample;
        last_stop = (UART_STOPBIT == 1) || stopcnt_reg;
        // A break ends at the first stop capture; a second stop bit is never waited for.
        brk_now   = (state_reg == S_STOP) && !stopcnt_reg && !sample && (data_reg == 9'd0)
                    && ((PARITY == 0) || !par_bit_reg);
        complete  = (state_reg == S_STOP) && capture && (brk_now || last_stop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            sync_reg      <= 2'b11;
            hist_reg      <= 3'b111;
            prime_reg     <= 2'b00;
            armed_reg     <= 1'b0;
            divcount_reg  <= 16'd0;
            bitcnt_reg    <= 4'd0;
            stopcnt_reg   <= 1'b0;
            data_reg      <= 9'd0;
            par_bit_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
            ferr_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 9'd0;
            out_error_reg <= 4'd0;
            rts_reg       <= 1'b0;
        end else if (clk_ena) begin
            sync_reg  <= {sync_reg[0], rxd};
            hist_reg  <= {hist_reg[1:0], rxd_s};
            // The reset-value 1s in the synchroniser are not a real idle line;
            // starts are armed only once a genuine high has come through.
            prime_reg <= {prime_reg[0], 1'b1};
            if (prime_reg[1] && rxd_s) begin
                armed_reg <= 1'b1;
            end
            rts_reg <= !(out_valid_reg && !stream.out_ready);

            if (state_reg != S_IDLE && state_reg != S_WAIT_IDLE) begin
                divcount_reg <= capture ? DIVNUM : divcount_reg - 16'd1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (armed_reg && hist_reg[0] && !rxd_s) begin
                        divcount_reg <= HALF;
                        state_reg    <= S_START;
                    end
                end
                S_START: begin
                    if (capture) begin
                        if (sample) begin
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg   <= S_DATA;
                            bitcnt_reg  <= 4'd0;
                            stopcnt_reg <= 1'b0;
                            data_reg    <= 9'd0;
                            par_bit_reg <= 1'b0;
                            par_err_reg <= 1'b0;
                            ferr_reg    <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (capture) begin
                        data_reg[bitcnt_reg] <= sample;
                        bitcnt_reg           <= bitcnt_reg + 4'd1;
                        if (bitcnt_reg == LAST_BIT) begin
                            state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (capture) begin
                        par_bit_reg <= sample;
                        par_err_reg <= (^data_reg ^ sample) != (PARITY == 1);
                        state_reg   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (capture) begin
                        if (complete) begin
                            state_reg <= brk_now ? S_WAIT_IDLE : S_IDLE;
                        end else begin
                            stopcnt_reg <= 1'b1;
                            ferr_reg    <= stop_ferr;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            // A completion always wins the slot; overflow is flagged only if the
            // previous frame was still pending and not taken this cycle.
            if (complete) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= brk_now ? 9'd0 : data_reg;
                out_error_reg <= {brk_now, par_err_reg && !brk_now, stop_ferr, out_valid_reg && !accept};
            end else if (accept) begin
                out_valid_reg    <= 1'b0;
                out_error_reg[0] <= 1'b0;
            end
        end
    end

    assign stream.out_valid = out_valid_reg;
    assign stream.out_data  = out_data_reg;
    assign stream.out_error = out_error_reg;
    assign rts              = rts_reg;

endmodule

// File: tb/tb_uart_phy_rxd_ex.sv
// Bench for uart_phy_rxd_ex: three receivers (8N1, 7E1, 8N2) at 10 clocks per bit,
// a vector table for single frames and directed sequences for multi-cycle corners.
module tb_uart_phy_rxd_ex;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       phase = 1'b0;
    logic       ena_tog = 1'b0;
    logic [2:0] rxd_v = 3'b111;
    logic [2:0] ready_v = 3'b111;
    logic [2:0] rst_v = 3'b111;
    logic [2:0] ena_w;
    logic [2:0] o_valid;
    logic [2:0] o_rts;
    logic [8:0] o_data [3];
    logic [3:0] o_err [3];

    int         acc_cnt [3];
    int         vcyc [3];
    int         rts_low [3];
    logic [8:0] acc_data [3];
    logic [3:0] acc_err [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    always @(negedge clk) phase = ~phase;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        uart_phy_rxd_ex_if bus ();
        assign ena_w[gi]     = (ena_tog && gi == 0) ? phase : 1'b1;
        assign bus.out_ready = ready_v[gi];
        assign o_valid[gi]   = bus.out_valid;
        assign o_data[gi]    = bus.out_data;
        assign o_err[gi]     = bus.out_error;

        uart_phy_rxd_ex #(
            .CLOCK_FREQUENCY(1000000),
            .UART_BAUDRATE  (100000),
            .DATA_BITS      ((gi == 1) ? 7 : 8),
            .PARITY         ((gi == 1) ? 2 : 0),
            .UART_STOPBIT   ((gi == 2) ? 2 : 1)
        ) dut (
            .clk    (clk),
            .reset  (rst_v[gi]),
            .clk_ena(ena_w[gi]),
            .rxd    (rxd_v[gi]),
            .rts    (o_rts[gi]),
            .stream (bus)
        );
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            acc_cnt[k] = 0; vcyc[k] = 0; rts_low[k] = 0; acc_data[k] = '0; acc_err[k] = '0;
        end
    end

    // Handshake monitor: values seen at negedge are what the DUT samples next posedge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_v[k]) begin
                if (!o_rts[k]) rts_low[k] = rts_low[k] + 1;
                if (ena_w[k] && o_valid[k]) begin
                    vcyc[k] = vcyc[k] + 1;
                    if (ready_v[k]) begin
                        acc_cnt[k]  = acc_cnt[k] + 1;
                        acc_data[k] = o_data[k];
                        acc_err[k]  = o_err[k];
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input int k, input logic v, input int cpb, input bit glitch);
        for (int c = 0; c < cpb; c++) begin
            @(posedge clk); #1;
            rxd_v[k] = (glitch && c == cpb / 2) ? ~v : v;
        end
    endtask

    task automatic send_frame(input int k, input logic [8:0] d, input logic pb,
                              input logic [1:0] sb, input int cpb, input int gbit);
        int nbits;
        nbits = (k == 1) ? 7 : 8;
        drive_bit(k, 1'b0, cpb, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(k, d[i], cpb, i == gbit);
        if (k == 1) drive_bit(k, pb, cpb, 1'b0);
        drive_bit(k, sb[0], cpb, 1'b0);
        if (k == 2) drive_bit(k, sb[1], cpb, 1'b0);
        @(posedge clk); #1;
        rxd_v[k] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        int         dut;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        int         cpb;
        int         gbit;
        bit         tog;
        logic [8:0] exp_data;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int base_acc, base_v, base_r;

        vecs[0] = '{"8n1_a5",         0, 9'h0A5, 1'b0, 2'b11, CPB,     -1, 1'b0, 9'h0A5, 4'b0000};
        vecs[1] = '{"8n1_a5_ena",     0, 9'h0A5, 1'b0, 2'b11, 2 * CPB, -1, 1'b1, 9'h0A5, 4'b0000};
        vecs[2] = '{"7e1_35_par0",    1, 9'h035, 1'b0, 2'b11, CPB,     -1, 1'b0, 9'h035, 4'b0000};
        vecs[3] = '{"7e1_35_par1",    1, 9'h035, 1'b1, 2'b11, CPB,     -1, 1'b0, 9'h035, 4'b0100};
        vecs[4] = '{"8n1_00_glitch",  0, 9'h000, 1'b0, 2'b11, CPB,      3, 1'b0, 9'h000, 4'b0000};
        vecs[5] = '{"8n1_81_stop0",   0, 9'h081, 1'b0, 2'b10, CPB,     -1, 1'b0, 9'h081, 4'b0010};
        vecs[6] = '{"8n2_3c_stop2lo", 2, 9'h03C, 1'b0, 2'b01, CPB,     -1, 1'b0, 9'h03C, 4'b0010};
        vecs[7] = '{"7e1_7f",         1, 9'h07F, 1'b1, 2'b11, CPB,     -1, 1'b0, 9'h07F, 4'b0000};

        // Reset values
        idle(5);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), 32'(o_valid[k]), 32'd0);
            check($sformatf("rst_data%0d", k),  32'(o_data[k]),  32'd0);
            check($sformatf("rst_err%0d", k),   32'(o_err[k]),   32'd0);
            check($sformatf("rst_rts%0d", k),   32'(o_rts[k]),   32'd0);
        end
        @(posedge clk); #1;
        rst_v = 3'b000;
        idle(20);

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            int k;
            k = vecs[v].dut;
            base_acc = acc_cnt[k]; base_v = vcyc[k]; base_r = rts_low[k];
            ena_tog = vecs[v].tog;
            send_frame(k, vecs[v].data, vecs[v].pbit, vecs[v].stops, vecs[v].cpb, vecs[v].gbit);
            idle(30);
            ena_tog = 1'b0;
            idle(10);
            check({vecs[v].name, "_count"}, 32'(acc_cnt[k] - base_acc), 32'd1);
            check({vecs[v].name, "_vcyc"},  32'(vcyc[k] - base_v),      32'd1);
            check({vecs[v].name, "_data"},  32'(acc_data[k]),           32'(vecs[v].exp_data));
            check({vecs[v].name, "_err"},   32'(acc_err[k]),            32'(vecs[v].exp_err));
            check({vecs[v].name, "_rts"},   32'(rts_low[k] - base_r),   32'd0);
            $display("vec %s dut%0d: data=0x%03h err=%b", vecs[v].name, k, acc_data[k], acc_err[k]);
        end

        // False start: one-clock low pulse on an idle line
        base_acc = acc_cnt[0];
        @(posedge clk); #1; rxd_v[0] = 1'b0;
        @(posedge clk); #1; rxd_v[0] = 1'b1;
        idle(40);
        check("false_start_count", 32'(acc_cnt[0] - base_acc), 32'd0);
        check("false_start_valid", 32'(o_valid[0]), 32'd0);
        $display("seq false_start: frames=%0d", acc_cnt[0] - base_acc);

        // Break: line low for 15 bit times, then a normal frame
        base_acc = acc_cnt[0];
        @(posedge clk); #1; rxd_v[0] = 1'b0;
        idle(15 * CPB);
        rxd_v[0] = 1'b1;
        idle(40);
        check("break_count", 32'(acc_cnt[0] - base_acc), 32'd1);
        check("break_data",  32'(acc_data[0]), 32'd0);
        check("break_err",   32'(acc_err[0]),  32'b1010);
        $display("seq break: frames=%0d data=0x%03h err=%b", acc_cnt[0] - base_acc, acc_data[0], acc_err[0]);
        base_acc = acc_cnt[0];
        send_frame(0, 9'h05A, 1'b0, 2'b11, CPB, -1);
        idle(30);
        check("after_break_count", 32'(acc_cnt[0] - base_acc), 32'd1);
        check("after_break_data",  32'(acc_data[0]), 32'h05A);
        check("after_break_err",   32'(acc_err[0]),  32'd0);
        $display("seq after_break: data=0x%03h err=%b", acc_data[0], acc_err[0]);

        // Overflow, then a completion coinciding with the accept
        ready_v[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 2'b11, CPB, -1);
        idle(20);
        @(negedge clk);
        check("ovf1_valid", 32'(o_valid[0]), 32'd1);
        check("ovf1_data",  32'(o_data[0]),  32'h011);
        check("ovf1_err",   32'(o_err[0]),   32'd0);
        check("ovf1_rts",   32'(o_rts[0]),   32'd0);
        $display("seq ovf1: data=0x%03h err=%b rts=%b", o_data[0], o_err[0], o_rts[0]);
        send_frame(0, 9'h022, 1'b0, 2'b11, CPB, -1);
        idle(20);
        @(negedge clk);
        check("ovf2_valid", 32'(o_valid[0]), 32'd1);
        check("ovf2_data",  32'(o_data[0]),  32'h022);
        check("ovf2_err",   32'(o_err[0]),   32'b0001);
        $display("seq ovf2: data=0x%03h err=%b", o_data[0], o_err[0]);
        fork
            send_frame(0, 9'h033, 1'b0, 2'b11, CPB, -1);
            begin
                // Stop capture of an 8N1 frame is 98 clocks after the start edge is driven.
                @(posedge clk);
                repeat (97) @(posedge clk);
                #1 ready_v[0] = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("overlap_valid", 32'(o_valid[0]), 32'd1);
                check("overlap_data",  32'(o_data[0]),  32'h033);
                check("overlap_err",   32'(o_err[0]),   32'd0);
                $display("seq overlap: data=0x%03h err=%b", o_data[0], o_err[0]);
                @(negedge clk);
                check("overlap_drain", 32'(o_valid[0]), 32'd0);
            end
        join
        idle(20);

        // Reset mid-data on the 8N2 receiver with the line low
        base_acc = acc_cnt[2];
        @(posedge clk); #1; rxd_v[2] = 1'b0;
        idle(25);
        rst_v[2] = 1'b1;
        idle(4);
        @(negedge clk);
        check("midrst_valid", 32'(o_valid[2]), 32'd0);
        check("midrst_data",  32'(o_data[2]),  32'd0);
        check("midrst_err",   32'(o_err[2]),   32'd0);
        check("midrst_rts",   32'(o_rts[2]),   32'd0);
        @(posedge clk); #1; rst_v[2] = 1'b0;
        idle(40);
        rxd_v[2] = 1'b1;
        idle(40);
        check("midrst_count", 32'(acc_cnt[2] - base_acc), 32'd0);
        $display("seq midrst: frames=%0d", acc_cnt[2] - base_acc);
        base_acc = acc_cnt[2];
        send_frame(2, 9'h03C, 1'b0, 2'b11, CPB, -1);
        idle(30);
        check("post_rst_count", 32'(acc_cnt[2] - base_acc), 32'd1);
        check("post_rst_data",  32'(acc_data[2]), 32'h03C);
        check("post_rst_err",   32'(acc_err[2]),  32'd0);
        $display("seq post_rst: data=0x%03h err=%b", acc_data[2], acc_err[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
